// File: rtl/uni_shift_seq.sv
// uni_shift_seq: parametrised universal shift register that runs N-step commands behind a valid/ready handshake.
// Optional abort/aborted ports are enabled by defining USHIFT_ABORT_EN.
module uni_shift_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_L,
  input  logic             serial_in_R,
`ifdef USHIFT_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_L,
  output logic             serial_out_R
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] q_q, q_d, pin_q;
  logic             busy_q, done_q;
`ifdef USHIFT_ABORT_EN
  logic             aborted_q;
  assign aborted = aborted_q;
`endif
  assign cmd_ready    = state_q == IDLE;
  assign busy         = busy_q;
  assign done         = done_q;
  assign q            = q_q;
  assign serial_out_L = q_q[WIDTH-1];
  assign serial_out_R = q_q[0];
  always_comb begin
    case (mode_q)
      3'b001:  q_d = {serial_in_R, q_q[WIDTH-1:1]};
      3'b010:  q_d = {q_q[WIDTH-2:0], serial_in_L};
      3'b011:  q_d = pin_q;
      3'b100:  q_d = {q_q[0], q_q[WIDTH-1:1]};
      3'b101:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      3'b110:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      default: q_d = q_q;
    endcase
  end
  // Load data is captured at accept so parallel_in need not be held until the step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      rem_q     <= '0;
      pin_q     <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef USHIFT_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef USHIFT_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (cmd_valid) begin
          mode_q <= cmd_mode;
          pin_q  <= parallel_in;
          rem_q  <= (cmd_mode == 3'b011) ? CNT_W'(1) : cmd_count;
          if (cmd_mode == 3'b011 || cmd_count != '0) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        RUN: begin
`ifdef USHIFT_ABORT_EN
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
`else
          begin
`endif
            q_q   <= q_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
